// File: rtl/cv32e40p_apu_resp_buf.sv
// cv32e40p_apu_resp_buf: credit-gated FPU request forwarding with an in-order response FIFO,
// flush-driven discard of in-flight results and a sticky unexpected-response error.
module cv32e40p_apu_resp_buf #(
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 32,
    parameter int FLAGS_W = 5,
    parameter int TAG_W   = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_i,
    input  logic [TAG_W-1:0]   tag_i,
    output logic               gnt_o,
    output logic               fpu_req_o,
    input  logic               fpu_gnt_i,
    input  logic               fpu_rvalid_i,
    input  logic [DATA_W-1:0]  fpu_rdata_i,
    input  logic [FLAGS_W-1:0] fpu_rflags_i,
    input  logic [TAG_W-1:0]   fpu_tag_i,
    output logic               rvalid_o,
    input  logic               rready_i,
    output logic [DATA_W-1:0]  rdata_o,
    output logic [FLAGS_W-1:0] rflags_o,
    output logic [TAG_W-1:0]   rtag_o,
    input  logic               flush_i,
    output logic               busy_o,
    output logic               err_o
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int SW  = CW + 1;
    localparam int EW  = DATA_W + FLAGS_W + TAG_W;
    localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);

    logic [CW-1:0] inflight_q, inflight_d, count_q, count_d, discard_q, discard_d;
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic          err_q, err_d;
    logic [EW-1:0] mem_q [DEPTH];
    logic [SW-1:0] occ;
    logic          credit_ok, resp_ok, push, pop;
    logic          unused_tag;

    // The tag travels to the FPU alongside the request; nothing here keeps it.
    assign unused_tag = ^tag_i;

    // Reserved slots (in flight + buffered) never exceed DEPTH, so every response has room.
    assign occ       = {1'b0, inflight_q} + {1'b0, count_q};
    assign credit_ok = rst_i | ((occ < DEPTH_S) & ~flush_i);
    assign fpu_req_o = req_i & credit_ok;
    assign gnt_o     = fpu_req_o & fpu_gnt_i;

    assign resp_ok = fpu_rvalid_i & (inflight_q != '0);
    assign push    = resp_ok & ~flush_i & (discard_q == '0);
    assign pop     = rvalid_o & rready_i & ~flush_i;

    always_comb begin
        inflight_d = inflight_q + CW'(gnt_o) - CW'(resp_ok);
        discard_d  = flush_i ? inflight_d : discard_q - CW'(resp_ok & (discard_q != '0));
        count_d    = flush_i ? '0 : count_q + CW'(push) - CW'(pop);
        wptr_d     = flush_i ? '0 : wptr_q + PW'(push);
        rptr_d     = flush_i ? '0 : rptr_q + PW'(pop);
        err_d      = err_q | (fpu_rvalid_i & (inflight_q == '0));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inflight_q <= '0;
            count_q    <= '0;
            discard_q  <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            count_q    <= count_d;
            discard_q  <= discard_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= {fpu_rdata_i, fpu_rflags_i, fpu_tag_i};
    end

    assign {rdata_o, rflags_o, rtag_o} = mem_q[rptr_q];
    assign rvalid_o = count_q != '0;
    assign busy_o   = (inflight_q != '0) | (count_q != '0);
    assign err_o    = err_q;
endmodule

// File: tb/tb_cv32e40p_apu_resp_buf.sv
// tb_cv32e40p_apu_resp_buf: random traffic against a queue-based reference model with a
// decoupled response monitor; covers reset, credit stalls, flushes and unexpected responses.
module tb_cv32e40p_apu_resp_buf;
    localparam int DEPTH   = 4;
    localparam int DATA_W  = 32;
    localparam int FLAGS_W = 5;
    localparam int TAG_W   = 4;
    localparam int EW      = DATA_W + FLAGS_W + TAG_W;

    logic               clk_i = 1'b0, rst_i = 1'b1;
    logic               req_i = 1'b0, fpu_gnt_i = 1'b0, fpu_rvalid_i = 1'b0;
    logic               rready_i = 1'b0, flush_i = 1'b0;
    logic [TAG_W-1:0]   tag_i = '0, fpu_tag_i = '0, rtag_o;
    logic [DATA_W-1:0]  fpu_rdata_i = '0, rdata_o;
    logic [FLAGS_W-1:0] fpu_rflags_i = '0, rflags_o;
    logic               gnt_o, fpu_req_o, rvalid_o, busy_o, err_o;

    cv32e40p_apu_resp_buf #(.DEPTH(DEPTH), .DATA_W(DATA_W), .FLAGS_W(FLAGS_W), .TAG_W(TAG_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .tag_i(tag_i), .gnt_o(gnt_o),
        .fpu_req_o(fpu_req_o), .fpu_gnt_i(fpu_gnt_i), .fpu_rvalid_i(fpu_rvalid_i),
        .fpu_rdata_i(fpu_rdata_i), .fpu_rflags_i(fpu_rflags_i), .fpu_tag_i(fpu_tag_i),
        .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o), .rflags_o(rflags_o),
        .rtag_o(rtag_o), .flush_i(flush_i), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0, errors = 0;
    logic [EW-1:0]    exp_q [$];
    logic [TAG_W-1:0] fpu_pend [$];
    int m_inflight = 0, m_discard = 0;
    bit m_err = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every response the DUT hands over must be the oldest expected one.
    always @(negedge clk_i) begin
        #2;
        if (!rst_i) begin
            chk("rvalid", 64'(rvalid_o), 64'(exp_q.size() != 0));
            if (rvalid_o && rready_i && !flush_i && exp_q.size() != 0)
                chk("resp_data", 64'({rdata_o, rflags_o, rtag_o}), 64'(exp_q.pop_front()));
        end
    end

    task automatic step(input int p_req, input int p_rdy, input int p_flush, input int p_rsp);
        bit e_req, e_gnt, rsp, fl;
        logic [EW-1:0] ent;
        logic [TAG_W-1:0] itag;
        @(negedge clk_i);
        req_i        = $urandom_range(99) < p_req;
        tag_i        = TAG_W'($urandom);
        fpu_gnt_i    = $urandom_range(3) != 0;
        rready_i     = $urandom_range(99) < p_rdy;
        flush_i      = $urandom_range(99) < p_flush;
        rsp          = fpu_pend.size() != 0 && $urandom_range(99) < p_rsp;
        fpu_rvalid_i = rsp;
        fpu_rdata_i  = $urandom;
        fpu_rflags_i = FLAGS_W'($urandom);
        fpu_tag_i    = rsp ? fpu_pend[0] : TAG_W'($urandom);
        ent  = {fpu_rdata_i, fpu_rflags_i, fpu_tag_i};
        fl   = flush_i;
        itag = tag_i;
        #1;
        e_req = req_i && !fl && (m_inflight + exp_q.size() < DEPTH);
        e_gnt = e_req && fpu_gnt_i;
        chk("fpu_req", 64'(fpu_req_o), 64'(e_req));
        chk("gnt", 64'(gnt_o), 64'(e_gnt));
        chk("busy", 64'(busy_o), 64'(m_inflight != 0 || exp_q.size() != 0));
        chk("err", 64'(err_o), 64'(m_err));
        @(posedge clk_i);
        if (rsp) void'(fpu_pend.pop_front());
        if (e_gnt) fpu_pend.push_back(itag);
        if (rsp && m_inflight == 0) m_err = 1'b1;
        else if (rsp && (fl || m_discard > 0)) begin
            m_inflight--;
            if (!fl) m_discard--;
        end else if (rsp) begin
            m_inflight--;
            exp_q.push_back(ent);
        end
        if (e_gnt) m_inflight++;
        if (fl) begin
            exp_q.delete();
            m_discard = m_inflight;
        end
    endtask

    initial begin
        req_i = 1'b1; flush_i = 1'b1; fpu_gnt_i = 1'b1;
        #12;
        chk("rst_rvalid", 64'(rvalid_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_err", 64'(err_o), 64'(0));
        chk("rst_fpu_req", 64'(fpu_req_o), 64'(1));
        chk("rst_gnt", 64'(gnt_o), 64'(1));
        @(negedge clk_i);
        rst_i = 1'b0; flush_i = 1'b0; req_i = 1'b0;
        for (int i = 0; i < 400; i++) step(70, 90, 4, 50);
        for (int i = 0; i < 400; i++) step(90, 15, 3, 60);
        for (int i = 0; i < 300; i++) step(80, 60, 10, 40);
        // Reset in the middle of traffic: everything still at the FPU becomes unexpected.
        @(negedge clk_i);
        #3;
        rst_i = 1'b1; req_i = 1'b0; fpu_rvalid_i = 1'b0; flush_i = 1'b0;
        exp_q.delete(); m_inflight = 0; m_discard = 0;
        #1;
        chk("midrst_rvalid", 64'(rvalid_o), 64'(0));
        chk("midrst_busy", 64'(busy_o), 64'(0));
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        if (fpu_pend.size() == 0) fpu_pend.push_back(4'h5);
        for (int i = 0; i < 100 && fpu_pend.size() != 0; i++) step(0, 50, 0, 60);
        chk("pend_drained", 64'(fpu_pend.size()), 64'(0));
        @(negedge clk_i);
        #1;
        chk("err_set", 64'(err_o), 64'(m_err));
        chk("err_no_buf", 64'(rvalid_o), 64'(0));
        for (int i = 0; i < 200; i++) step(70, 70, 5, 50);
        @(negedge clk_i);
        #1;
        chk("err_sticky", 64'(err_o), 64'(1));
        #2;
        rst_i = 1'b1;
        #1;
        chk("err_cleared", 64'(err_o), 64'(0));
        chk("final_busy", 64'(busy_o), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
